// File: rtl/dict_loader_if.sv
// ============================================================================
//  Module   : dict_loader_if
//  Brief    : Image-memory read bus and dictionary write ports used by
//             dict_loader (master side) and the memory/controller (slave side).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface dict_loader_if #(
    parameter int F1_VAL_W = 7,
    parameter int F2_VAL_W = 10,
    parameter int F3_VAL_W = 15
);
    // Image memory read channel
    logic                mem_valid;
    logic                mem_ready;
    logic [31:0]         mem_addr;
    logic [31:0]         mem_rdata;

    // Controller dictionary write ports
    logic                dict1_write_enable;
    logic [F1_VAL_W-1:0] dict1_write_val;
    logic                dict2_write_enable;
    logic [F2_VAL_W-1:0] dict2_write_val;
    logic                dict3_write_enable;
    logic [F3_VAL_W-1:0] dict3_write_val;

    modport master (
        output mem_valid,
        output mem_addr,
        input  mem_ready,
        input  mem_rdata,
        output dict1_write_enable,
        output dict1_write_val,
        output dict2_write_enable,
        output dict2_write_val,
        output dict3_write_enable,
        output dict3_write_val
    );

    modport slave (
        input  mem_valid,
        input  mem_addr,
        output mem_ready,
        output mem_rdata,
        input  dict1_write_enable,
        input  dict1_write_val,
        input  dict2_write_enable,
        input  dict2_write_val,
        input  dict3_write_enable,
        input  dict3_write_val
    );
endinterface

`default_nettype wire

// File: rtl/dict_loader.sv
// ============================================================================
//  Module   : dict_loader
//  Brief    : Boot-time loader that streams a contiguous dictionary image from
//             memory into three controller dictionaries, one entry at a time,
//             then releases the core/controller reset.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dict_loader #(
    parameter int          F1_VAL_W  = 7,
    parameter int          F2_VAL_W  = 10,
    parameter int          F3_VAL_W  = 15,
    parameter int          F1_KEY_W  = 3,
    parameter int          F2_KEY_W  = 5,
    parameter int          F3_KEY_W  = 8,
    parameter logic [31:0] DICT_BASE = 32'h000F_0000
) (
    input  wire logic         clk,
    input  wire logic         reset,
    input  wire logic         start,
    dict_loader_if.master     bus,
    output logic              proc_resetn,
    output logic              busy,
    output logic              done,
    output logic              format_err,
    output logic [9:0]        entries_written
);

    localparam int DEPTH1 = 2 ** F1_KEY_W;
    localparam int DEPTH2 = 2 ** F2_KEY_W;
    localparam int DEPTH3 = 2 ** F3_KEY_W;
    localparam int TOTAL  = DEPTH1 + DEPTH2 + DEPTH3;
    localparam int G_W    = $clog2(TOTAL);
    localparam int IDX_W  = (F1_KEY_W > F2_KEY_W)
                          ? ((F1_KEY_W > F3_KEY_W) ? F1_KEY_W : F3_KEY_W)
                          : ((F2_KEY_W > F3_KEY_W) ? F2_KEY_W : F3_KEY_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              r_state;
    logic [G_W-1:0]      r_g;          // global image word index
    logic [IDX_W-1:0]    r_idx;        // entry index inside the current region
    logic [1:0]          r_region;     // 1, 2 or 3
    logic                r_armed;      // low for the first edge after reset release

    logic                r_mem_valid;
    logic [31:0]         r_mem_addr;
    logic                r_we1;
    logic                r_we2;
    logic                r_we3;
    logic [F1_VAL_W-1:0] r_val1;
    logic [F2_VAL_W-1:0] r_val2;
    logic [F3_VAL_W-1:0] r_val3;
    logic                r_proc_resetn;
    logic                r_busy;
    logic                r_done;
    logic                r_format_err;
    logic [9:0]          r_entries;

    logic [IDX_W-1:0]    w_region_last;
    logic                w_fmt_bad;
    logic [G_W-1:0]      w_g_next;

    // Last in-region index and out-of-range check for the word being returned
    always_comb begin
        w_region_last = '0;
        w_fmt_bad     = 1'b0;
        case (r_region)
            2'd1: begin
                w_region_last = IDX_W'(DEPTH1 - 1);
                w_fmt_bad     = (bus.mem_rdata >> F1_VAL_W) != 32'd0;
            end
            2'd2: begin
                w_region_last = IDX_W'(DEPTH2 - 1);
                w_fmt_bad     = (bus.mem_rdata >> F2_VAL_W) != 32'd0;
            end
            2'd3: begin
                w_region_last = IDX_W'(DEPTH3 - 1);
                w_fmt_bad     = (bus.mem_rdata >> F3_VAL_W) != 32'd0;
            end
            default: begin
                w_region_last = '0;
                w_fmt_bad     = 1'b0;
            end
        endcase
    end

    assign w_g_next = r_g + G_W'(1);

    // Gate start for one edge after reset release so a start pulse that
    // overlaps the release can never launch a load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_armed <= 1'b0;
        end else begin
            r_armed <= 1'b1;
        end
    end

    // Load sequencer: every output is a register updated on state transitions
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_g           <= '0;
            r_idx         <= '0;
            r_region      <= 2'd1;
            r_mem_valid   <= 1'b0;
            r_mem_addr    <= 32'd0;
            r_we1         <= 1'b0;
            r_we2         <= 1'b0;
            r_we3         <= 1'b0;
            r_val1        <= '0;
            r_val2        <= '0;
            r_val3        <= '0;
            r_proc_resetn <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_format_err  <= 1'b0;
            r_entries     <= 10'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start && r_armed) begin
                        r_state     <= FETCH;
                        r_g         <= '0;
                        r_idx       <= '0;
                        r_region    <= 2'd1;
                        r_mem_valid <= 1'b1;
                        r_mem_addr  <= DICT_BASE;
                        r_busy      <= 1'b1;
                    end
                end

                FETCH: begin
                    // Address and valid stay put until the memory answers;
                    // the returned word is captured straight into the port
                    // register of the active dictionary.
                    if (bus.mem_ready) begin
                        r_state      <= WRITE;
                        r_mem_valid  <= 1'b0;
                        r_format_err <= r_format_err | w_fmt_bad;
                        r_entries    <= r_entries + 10'd1;
                        case (r_region)
                            2'd1: begin
                                r_we1  <= 1'b1;
                                r_val1 <= bus.mem_rdata[F1_VAL_W-1:0];
                            end
                            2'd2: begin
                                r_we2  <= 1'b1;
                                r_val2 <= bus.mem_rdata[F2_VAL_W-1:0];
                            end
                            default: begin
                                r_we3  <= 1'b1;
                                r_val3 <= bus.mem_rdata[F3_VAL_W-1:0];
                            end
                        endcase
                    end
                end

                WRITE: begin
                    r_we1 <= 1'b0;
                    r_we2 <= 1'b0;
                    r_we3 <= 1'b0;
                    if ((r_region == 2'd3) && (r_idx == w_region_last)) begin
                        r_state       <= DONE;
                        r_busy        <= 1'b0;
                        r_done        <= 1'b1;
                        r_proc_resetn <= 1'b1;
                    end else begin
                        r_state     <= FETCH;
                        r_g         <= w_g_next;
                        r_mem_valid <= 1'b1;
                        r_mem_addr  <= DICT_BASE + (32'(w_g_next) << 2);
                        if (r_idx == w_region_last) begin
                            r_idx    <= '0;
                            r_region <= r_region + 2'd1;
                        end else begin
                            r_idx    <= r_idx + IDX_W'(1);
                        end
                    end
                end

                DONE: begin
                    // Terminal until reset; start is ignored here.
                    r_state <= DONE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_valid          = r_mem_valid;
    assign bus.mem_addr           = r_mem_addr;
    assign bus.dict1_write_enable = r_we1;
    assign bus.dict1_write_val    = r_val1;
    assign bus.dict2_write_enable = r_we2;
    assign bus.dict2_write_val    = r_val2;
    assign bus.dict3_write_enable = r_we3;
    assign bus.dict3_write_val    = r_val3;

    assign proc_resetn     = r_proc_resetn;
    assign busy            = r_busy;
    assign done            = r_done;
    assign format_err      = r_format_err;
    assign entries_written = r_entries;

endmodule

`default_nettype wire

// File: tb/tb_dict_loader.sv
// ============================================================================
//  Module   : tb_dict_loader
//  Brief    : Self-checking bench for dict_loader: table of image words with
//             hand-computed dictionary writes, plus directed sequences for
//             memory stalls, mid-load reset, start gating and restart.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_dict_loader;

    localparam int          F1V  = 7;
    localparam int          F2V  = 10;
    localparam int          F3V  = 15;
    localparam logic [31:0] BASE = 32'h000F_0000;
    localparam int          N    = 296;
    localparam int          LOGN = 400;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       proc_resetn;
    logic       busy;
    logic       done;
    logic       format_err;
    logic [9:0] entries_written;

    dict_loader_if #(.F1_VAL_W(F1V), .F2_VAL_W(F2V), .F3_VAL_W(F3V)) bus_if ();

    dict_loader #(
        .F1_VAL_W(F1V), .F2_VAL_W(F2V), .F3_VAL_W(F3V),
        .F1_KEY_W(3), .F2_KEY_W(5), .F3_KEY_W(8),
        .DICT_BASE(BASE)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .bus(bus_if),
        .proc_resetn(proc_resetn),
        .busy(busy),
        .done(done),
        .format_err(format_err),
        .entries_written(entries_written)
    );

    always #5 clk = ~clk;

    // Memory model: ready rises once valid has been held for cur_wait cycles
    logic [31:0] image [0:N-1];
    int          cur_wait;
    int          wcnt;
    logic [31:0] word_idx;

    always @(posedge clk or posedge reset) begin
        if (reset) wcnt <= 0;
        else if (!bus_if.mem_valid || bus_if.mem_ready) wcnt <= 0;
        else wcnt <= wcnt + 1;
    end

    assign word_idx         = (bus_if.mem_addr - BASE) >> 2;
    assign bus_if.mem_ready = bus_if.mem_valid && (wcnt >= cur_wait);
    assign bus_if.mem_rdata = (word_idx < 32'(N)) ? image[word_idx[8:0]] : 32'hDEAD_BEEF;

    // Scoreboard state
    int checks   = 0;
    int failures = 0;

    int          wr_region [0:LOGN-1];
    logic [31:0] wr_val    [0:LOGN-1];
    int          wr_cyc    [0:LOGN-1];
    logic [31:0] fetch_addr[0:LOGN-1];
    int          nw, nf, cyc, overlap, multi, hold_viol, pr_viol, done_cyc;
    logic [31:0] prev1, prev2, prev3;
    logic        prev_rst;

    typedef struct {
        int          g;
        logic [31:0] word;
        int          region;
        logic [31:0] val;
        logic [31:0] addr;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int region_of(input int g);
        return (g < 8) ? 1 : ((g < 40) ? 2 : 3);
    endfunction

    function automatic logic [31:0] mask_of(input int r);
        return (r == 1) ? 32'h7F : ((r == 2) ? 32'h3FF : 32'h7FFF);
    endfunction

    task automatic clear_log();
        nw = 0; nf = 0; overlap = 0; multi = 0; hold_viol = 0; pr_viol = 0;
        done_cyc = -1;
    endtask

    task automatic sample();
        int nwe;
        cyc++;
        nwe = int'(bus_if.dict1_write_enable) + int'(bus_if.dict2_write_enable)
            + int'(bus_if.dict3_write_enable);
        if (bus_if.mem_valid && nwe != 0) overlap++;
        if (nwe > 1) multi++;
        if (bus_if.mem_valid && bus_if.mem_ready && nf < LOGN) begin
            fetch_addr[nf] = bus_if.mem_addr;
            nf++;
        end
        if (nwe == 1 && nw < LOGN) begin
            if (bus_if.dict1_write_enable) begin
                wr_region[nw] = 1; wr_val[nw] = 32'(bus_if.dict1_write_val);
            end else if (bus_if.dict2_write_enable) begin
                wr_region[nw] = 2; wr_val[nw] = 32'(bus_if.dict2_write_val);
            end else begin
                wr_region[nw] = 3; wr_val[nw] = 32'(bus_if.dict3_write_val);
            end
            wr_cyc[nw] = cyc;
            nw++;
        end
        if (!reset && !prev_rst) begin
            if (!bus_if.dict1_write_enable && 32'(bus_if.dict1_write_val) != prev1) hold_viol++;
            if (!bus_if.dict2_write_enable && 32'(bus_if.dict2_write_val) != prev2) hold_viol++;
            if (!bus_if.dict3_write_enable && 32'(bus_if.dict3_write_val) != prev3) hold_viol++;
        end
        if (busy && proc_resetn) pr_viol++;
        if (done && done_cyc < 0) done_cyc = cyc;
        prev1 = 32'(bus_if.dict1_write_val);
        prev2 = 32'(bus_if.dict2_write_val);
        prev3 = 32'(bus_if.dict3_write_val);
        prev_rst = reset;
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_until_done(input string tag, input int budget);
        int b = 0;
        while (!done && b < budget) begin
            tick();
            b++;
        end
        check({tag, "_done_in_budget"}, 32'(done), 32'd1);
    endtask

    // Every logged write against the image model: order, region, value,
    // fetch address and 3-cycle spacing with a one-cycle-latency memory
    task automatic check_sequence(input string tag);
        int errs = 0;
        int gaps = 0;
        for (int k = 0; k < nw && k < N; k++) begin
            if (wr_region[k] != region_of(k)) errs++;
            if (wr_val[k] != (image[k] & mask_of(region_of(k)))) errs++;
            if (fetch_addr[k] != BASE + 32'(4 * k)) errs++;
            if (k > 0 && (wr_cyc[k] - wr_cyc[k-1]) != 3) gaps++;
        end
        check({tag, "_write_count"}, 32'(nw), 32'(N));
        check({tag, "_fetch_count"}, 32'(nf), 32'(N));
        check({tag, "_seq_errors"}, 32'(errs), 32'd0);
        check({tag, "_spacing_errors"}, 32'(gaps), 32'd0);
        check({tag, "_fetch_write_overlap"}, 32'(overlap), 32'd0);
        check({tag, "_multi_enable"}, 32'(multi), 32'd0);
        check({tag, "_val_hold_errors"}, 32'(hold_viol), 32'd0);
        check({tag, "_resetn_while_busy"}, 32'(pr_viol), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_valid"}, 32'(bus_if.mem_valid), 32'd0);
        check({tag, "_mem_addr"}, bus_if.mem_addr, 32'd0);
        check({tag, "_write_enables"},
              32'({bus_if.dict1_write_enable, bus_if.dict2_write_enable, bus_if.dict3_write_enable}), 32'd0);
        check({tag, "_write_vals"},
              {bus_if.dict1_write_val, bus_if.dict2_write_val, bus_if.dict3_write_val}, 32'd0);
        check({tag, "_status"}, 32'({proc_resetn, busy, done, format_err}), 32'd0);
        check({tag, "_entries_written"}, 32'(entries_written), 32'd0);
    endtask

    task automatic fill_default_image();
        for (int g = 0; g < N; g++) image[g] = 32'(g * 37 + 5) & mask_of(region_of(g));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          b;
        int          start_cyc;
        int          nf_hold;
        int          stable_ok;
        logic [5:0]  rdy_bits;
        logic        pulsed;

        // g, image word, expected dictionary, expected value, expected fetch address
        vecs[0] = '{0,   32'h0000_0181, 1, 32'h01,   32'h000F_0000};
        vecs[1] = '{7,   32'h0000_007F, 1, 32'h7F,   32'h000F_001C};
        vecs[2] = '{8,   32'h0000_03A5, 2, 32'h3A5,  32'h000F_0020};
        vecs[3] = '{20,  32'h8000_0001, 2, 32'h001,  32'h000F_0050};
        vecs[4] = '{39,  32'h0000_03FF, 2, 32'h3FF,  32'h000F_009C};
        vecs[5] = '{40,  32'h0000_7FFF, 3, 32'h7FFF, 32'h000F_00A0};
        vecs[6] = '{295, 32'h0001_1234, 3, 32'h1234, 32'h000F_049C};

        start = 1'b0; reset = 1'b1; cur_wait = 1; cyc = 0;
        prev1 = '0; prev2 = '0; prev3 = '0; prev_rst = 1'b1;
        clear_log();
        fill_default_image();
        for (int i = 0; i < 7; i++) image[vecs[i].g] = vecs[i].word;

        repeat (3) tick();
        check_reset_outputs("reset");
        reset = 1'b0;
        repeat (3) tick();
        check("idle_no_activity", 32'({bus_if.mem_valid, busy}), 32'd0);

        // ---- Load A: full image, one-cycle-latency memory ----
        clear_log();
        do_start();
        start_cyc = cyc;
        run_until_done("loadA", 3000);
        check_sequence("loadA");
        check("loadA_first_write_latency", 32'(wr_cyc[0] - start_cyc), 32'd2);
        for (int i = 0; i < 7; i++) begin
            check($sformatf("vec%0d_region", vecs[i].g), 32'(wr_region[vecs[i].g]), 32'(vecs[i].region));
            check($sformatf("vec%0d_val", vecs[i].g), wr_val[vecs[i].g], vecs[i].val);
            check($sformatf("vec%0d_addr", vecs[i].g), fetch_addr[vecs[i].g], vecs[i].addr);
        end
        check("loadA_done_after_last_write", 32'(done_cyc - wr_cyc[N-1]), 32'd1);
        check("loadA_final_status", 32'({proc_resetn, busy, done, format_err}), 32'b1011);
        check("loadA_entries_written", 32'(entries_written), 32'd296);

        // start pulses in DONE must do nothing
        nf_hold = nf;
        do_start();
        repeat (2) tick();
        do_start();
        repeat (5) tick();
        check("done_start_no_fetch", 32'(nf), 32'(nf_hold));
        check("done_start_status", 32'({bus_if.mem_valid, busy, done}), 32'b001);
        check("done_start_entries", 32'(entries_written), 32'd296);

        // ---- Load B: stalled first word, then reset during fetch of g=100 ----
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (2) tick();
        cur_wait = 5;
        clear_log();
        do_start();
        stable_ok = 1;
        rdy_bits  = '0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            if (!(bus_if.mem_valid && bus_if.mem_addr == BASE && !bus_if.dict1_write_enable
                  && !bus_if.dict2_write_enable && !bus_if.dict3_write_enable))
                stable_ok = 0;
            rdy_bits[i] = bus_if.mem_ready;
        end
        check("stall_valid_addr_stable", 32'(stable_ok), 32'd1);
        check("stall_ready_pattern", 32'(rdy_bits), 32'b100000);
        check("stall_no_early_write", 32'(nw), 32'd0);
        cur_wait = 1;
        tick();
        check("stall_single_dict1_write",
              32'({bus_if.dict1_write_enable, bus_if.dict2_write_enable, bus_if.dict3_write_enable}), 32'b100);
        check("stall_dict1_val", 32'(bus_if.dict1_write_val), 32'h01);
        check("stall_format_err", 32'(format_err), 32'd1);

        b = 0;
        while (!(bus_if.mem_valid && bus_if.mem_addr == BASE + 32'd400) && b < 2000) begin
            tick();
            b++;
        end
        check("abort_reached_g100", 32'(bus_if.mem_valid && bus_if.mem_addr == BASE + 32'd400), 32'd1);
        check("abort_entries_before", 32'(entries_written), 32'd100);
        #2 reset = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        tick();
        tick();
        // start raised together with reset release: must be ignored
        reset = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        check("release_no_writes", 32'(nw), 32'd100);
        check("release_idle", 32'({bus_if.mem_valid, busy, done}), 32'd0);
        check("release_entries", 32'(entries_written), 32'd0);

        // ---- Load C: restart from g=0 with a clean image, start while busy ----
        fill_default_image();
        image[0] = 32'h0000_0055;
        clear_log();
        do_start();
        pulsed = 1'b0;
        b = 0;
        while (!done && b < 3000) begin
            if ((nw == 50 || nw == 200) && !pulsed) begin
                start = 1'b1;
                tick();
                start = 1'b0;
                pulsed = (nw == 200);
            end else begin
                tick();
            end
            b++;
        end
        check("loadC_done_in_budget", 32'(done), 32'd1);
        check_sequence("loadC");
        check("loadC_first_val", wr_val[0], 32'h55);
        check("loadC_final_status", 32'({proc_resetn, busy, done, format_err}), 32'b1010);
        check("loadC_entries_written", 32'(entries_written), 32'd296);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
